dram_line_responder: RTL and testbench



---
 rtl/dram_pkg.sv | 32 +++
 rtl/dram_line_array.sv | 26 ++
 rtl/dram_line_responder.sv | 135 +++++++++++++
 tb/tb_dram_line_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and default geometry for the DRAM line responder.
// The top module's parameters default to the DRAM_* constants defined here.
package dram_pkg;

    localparam int DRAM_B         = 64;
    localparam int DRAM_ADDR_BITS = 64;
    localparam int DRAM_MEM_LINES = 1024;
    localparam int DRAM_LATENCY   = 8;

    localparam int DRAM_OFF_BITS  = $clog2(DRAM_B);
    localparam int DRAM_IDX_BITS  = $clog2(DRAM_MEM_LINES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dram_state_t;

    typedef logic [DRAM_B*8-1:0] line_t;

    typedef struct packed {
        logic                      we;
        logic [DRAM_ADDR_BITS-1:0] addr;
        line_t                     line;
    } dram_req_t;

    // Storage index for the default geometry: offset bits dropped, upper bits wrap.
    function automatic logic [DRAM_IDX_BITS-1:0] line_index(input logic [DRAM_ADDR_BITS-1:0] addr);
        return addr[DRAM_OFF_BITS +: DRAM_IDX_BITS];
    endfunction

endpackage

// File: rtl/dram_line_array.sv
// Line storage for the DRAM responder: one synchronous write port, combinational read.
// Contents are not reset.
module dram_line_array
    import dram_pkg::*;
#(
    parameter int W     = DRAM_B * 8,
    parameter int DEPTH = DRAM_MEM_LINES
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dram_line_responder.sv
// DRAM-side responder for the cache lower-level port: one line access in flight, fixed latency.
// Optional DRAM_RESP_STATS_EN adds read/write completion counters.
module dram_line_responder
    import dram_pkg::*;
#(
    parameter int B         = DRAM_B,
    parameter int ADDR_BITS = DRAM_ADDR_BITS,
    parameter int MEM_LINES = DRAM_MEM_LINES,
    parameter int LATENCY   = DRAM_LATENCY
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 req_valid_in,
    input  logic                 req_we_in,
    input  logic [ADDR_BITS-1:0] req_addr_in,
    input  logic [B*8-1:0]       req_line_in,
    output logic                 req_ready_out,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [ADDR_BITS-1:0] resp_addr_out,
    output logic [B*8-1:0]       resp_line_out
`ifdef DRAM_RESP_STATS_EN
    ,
    output logic [31:0]          rd_count_out,
    output logic [31:0]          wr_count_out
`endif
);

    // Request side: accept when req_valid_in && req_ready_out at a posedge.
    // Response side: resp_valid_out holds with stable data until resp_valid_out && resp_ready_in.
    localparam int OFF_BITS = $clog2(B);
    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_BITS-1:0] LINE_MASK = {{(ADDR_BITS-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
    localparam logic [CNT_BITS-1:0]  CNT_LOAD  = CNT_BITS'(LATENCY - 1);

    dram_state_t           state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  we_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [B*8-1:0]        wline_q;
    logic [B*8-1:0]        rd_line;

    logic                  accept, done, handshake, mem_we;
    logic                  ready_d, valid_d;
    logic [ADDR_BITS-1:0]  addr_d;
    logic [B*8-1:0]        line_d;

    assign accept    = req_valid_in && req_ready_out;
    assign done      = (state_q == BUSY) && (cnt_q == '0);
    assign handshake = resp_valid_out && resp_ready_in;
    // Gating with rst_in drops a write whose commit lands on a reset edge.
    assign mem_we    = done && we_q && !rst_in;

    dram_line_array #(
        .W     (B * 8),
        .DEPTH (MEM_LINES)
    ) u_array (
        .clk_in (clk_in),
        .we     (mem_we),
        .addr   (addr_q[OFF_BITS +: IDX_BITS]),
        .wdata  (wline_q),
        .rdata  (rd_line)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_ready_out  <= 1'b0;
            resp_valid_out <= 1'b0;
            resp_addr_out  <= '0;
            resp_line_out  <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_out  <= ready_d;
            resp_valid_out <= valid_d;
            resp_addr_out  <= addr_d;
            resp_line_out  <= line_d;
            if (accept) begin
                cnt_q <= CNT_LOAD;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Request fields are captured only on the accept edge.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            we_q    <= req_we_in;
            addr_q  <= req_addr_in;
            wline_q <= req_line_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (done)      state_d = we_q ? IDLE : RESP;
            RESP:    if (handshake) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Ready rises one cycle after IDLE is entered, so it is low on the entry cycle.
    always_comb begin
        ready_d = (state_q == IDLE) && !accept;
        valid_d = resp_valid_out;
        addr_d  = resp_addr_out;
        line_d  = resp_line_out;
        if (done && !we_q) begin
            valid_d = 1'b1;
            addr_d  = addr_q & LINE_MASK;
            line_d  = rd_line;
        end
        if (state_q == RESP && handshake) begin
            valid_d = 1'b0;
        end
    end

`ifdef DRAM_RESP_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_count_out <= '0;
            wr_count_out <= '0;
        end else begin
            if (state_q == RESP && handshake) rd_count_out <= rd_count_out + 32'd1;
            if (mem_we)                      wr_count_out <= wr_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_line_responder.sv
// Directed self-checking bench for dram_line_responder (default geometry, LATENCY=8).
// Counter ports are checked when DRAM_RESP_STATS_EN is defined.
module tb_dram_line_responder;
    import dram_pkg::*;

    localparam int LAT = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_we_in;
    logic [63:0] req_addr_in;
    line_t       req_line_in;
    logic        req_ready_out;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [63:0] resp_addr_out;
    line_t       resp_line_out;
`ifdef DRAM_RESP_STATS_EN
    logic [31:0] rd_count_out;
    logic [31:0] wr_count_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    line_t exp_q[$];

    always #5 clk_in = ~clk_in;

    dram_line_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_we_in      (req_we_in),
        .req_addr_in    (req_addr_in),
        .req_line_in    (req_line_in),
        .req_ready_out  (req_ready_out),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_addr_out  (resp_addr_out),
        .resp_line_out  (resp_line_out)
`ifdef DRAM_RESP_STATS_EN
        ,
        .rd_count_out   (rd_count_out),
        .wr_count_out   (wr_count_out)
`endif
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Presents one request, returns just after the accept edge, then scrambles the inputs.
    task automatic send(input logic we, input logic [63:0] addr, input line_t line, output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        while (!req_ready_out && w < 40) begin
            tick();
            w++;
        end
        if (!req_ready_out) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        req_valid_in = 1'b1;
        req_we_in    = we;
        req_addr_in  = addr;
        req_line_in  = line;
        tick();
        req_valid_in = 1'b0;
        req_we_in    = ~we;
        req_addr_in  = {$urandom(), $urandom()};
        req_line_in  = rand_line();
        ok = 1'b1;
        check("ready_low_after_accept", req_ready_out, 0);
    endtask

    task automatic do_write(input logic [63:0] addr, input line_t line);
        bit ok;
        bit seen;
        send(1'b1, addr, line, ok);
        if (!ok) return;
        seen = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (resp_valid_out) seen = 1'b1;
            if (k == LAT)     check("wr_ready_low_at_lat", req_ready_out, 0);
            if (k == LAT + 1) check("wr_ready_high_at_lat1", req_ready_out, 1);
        end
        check("wr_no_response", seen, 0);
    endtask

    // Read with resp_ready_in already high: valid lasts exactly one cycle.
    task automatic do_read(input logic [63:0] addr, input logic [63:0] exp_addr);
        bit    ok;
        int    k;
        line_t exp_line;
        exp_line = exp_q.pop_front();
        resp_ready_in = 1'b1;
        send(1'b0, addr, rand_line(), ok);
        if (!ok) return;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (resp_valid_out) break;
        end
        check("rd_latency", k, LAT);
        check("rd_line", resp_line_out, exp_line);
        check("rd_addr", resp_addr_out, exp_addr);
        tick();
        check("rd_valid_one_cycle", resp_valid_out, 0);
        check("rd_ready_low_after_hs", req_ready_out, 0);
        tick();
        check("rd_ready_back", req_ready_out, 1);
    endtask

    task automatic do_reset(input int cycles);
        rst_in = 1'b1;
        repeat (cycles) tick();
        rst_in = 1'b0;
    endtask

    initial begin
        line_t l_a5, l_11, l_5a;
        bit    ok;
        bit    seen;
        int    k;
        l_a5 = {64{8'hA5}};
        l_11 = {64{8'h11}};
        l_5a = {64{8'h5A}};

        req_valid_in  = 1'b0;
        req_we_in     = 1'b0;
        req_addr_in   = '0;
        req_line_in   = '0;
        resp_ready_in = 1'b1;

        do_reset(2);
        check("rst_ready", req_ready_out, 0);
        check("rst_valid", resp_valid_out, 0);
        check("rst_addr", resp_addr_out, 0);
        check("rst_line", resp_line_out, 0);
        tick();
        check("ready_after_release", req_ready_out, 1);

        do_write(64'h1040, l_a5);
        exp_q.push_back(l_a5);
        do_read(64'h1040, 64'h1040);

        do_write(64'h0000, l_11);
        exp_q.push_back(l_11);
        do_read(64'h0038, 64'h0000);
        exp_q.push_back(l_11);
        do_read(64'h10000, 64'h10000);

        // Backpressure: response must hold for 20 cycles with no new accepts.
        resp_ready_in = 1'b0;
        send(1'b0, 64'h1047, rand_line(), ok);
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (resp_valid_out) break;
        end
        check("bp_latency", k, LAT);
        req_valid_in = 1'b1;
        req_we_in    = 1'b1;
        repeat (20) begin
            tick();
            check("bp_valid_held", resp_valid_out, 1);
            check("bp_line_held", resp_line_out, l_a5);
            check("bp_addr_held", resp_addr_out, 64'h1040);
            check("bp_ready_low", req_ready_out, 0);
        end
        req_valid_in  = 1'b0;
        resp_ready_in = 1'b1;
        tick();
        check("bp_valid_drop", resp_valid_out, 0);
        check("bp_ready_still_low", req_ready_out, 0);
        tick();
        check("bp_ready_back", req_ready_out, 1);

        // Reset three cycles into a read: that read must never respond.
        do_write(64'h2080, l_5a);
        send(1'b0, 64'h2080, rand_line(), ok);
        repeat (3) tick();
        do_reset(1);
        check("abort_valid", resp_valid_out, 0);
        check("abort_ready", req_ready_out, 0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (resp_valid_out) seen = 1'b1;
        end
        check("abort_no_response", seen, 0);
        exp_q.push_back(l_5a);
        do_read(64'h2080, 64'h2080);

        // Counter section: fresh reset, then 3 writes and 2 reads.
        do_reset(2);
        tick();
        do_write(64'h0040, l_11);
        do_write(64'h0080, l_5a);
        do_write(64'h00C0, l_a5);
        exp_q.push_back(l_5a);
        do_read(64'h0080, 64'h0080);
        exp_q.push_back(l_a5);
        do_read(64'h00C5, 64'h00C0);
`ifdef DRAM_RESP_STATS_EN
        check("wr_count", wr_count_out, 3);
        check("rd_count", rd_count_out, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
